// File: rtl/rc5_dec_16bit.sv
// rtl/rc5_dec_16bit.sv - RC5-style 16-bit block decryptor, one half-round per clock
// Define RC5_DEC_KEY_LATCH_EN to capture the key table on the accepting edge.
module rc5_dec_16bit #(
  parameter int ROUNDS = 1,
  localparam int KW = 2*ROUNDS + 2
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            dec_start,
  input  logic [15:0]     c,
  input  logic [8*KW-1:0] s,
  output logic [15:0]     p,
  output logic            dec_done,
  output logic            busy
);

  typedef enum logic [1:0] {IDLE, RND_B, RND_A, POST} state_t;

  state_t          state, state_n;
  logic [7:0]      a, b, a_n, b_n;
  logic [2:0]      r, r_n;
  logic [15:0]     p_n;
  logic            done_n, busy_n;
  logic [8*KW-1:0] key;
  logic [7:0]      key_a, key_b, key_0, key_1;

`ifdef RC5_DEC_KEY_LATCH_EN
  logic [8*KW-1:0] key_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      key_q <= '0;
    else if (state == IDLE && dec_start)
      key_q <= s;
  end

  assign key = key_q;
`else
  assign key = s;
`endif

  // Round keys for the current round r: S[2r] drives A, S[2r+1] drives B.
  assign key_a = key[16*r +: 8];
  assign key_b = key[16*r + 8 +: 8];
  assign key_0 = key[7:0];
  assign key_1 = key[15:8];

  function automatic logic [7:0] rotr8(input logic [7:0] x, input logic [2:0] n);
    logic [15:0] t;
    t = {x, x} >> n;
    return t[7:0];
  endfunction

  always_comb begin
    state_n = state;
    a_n     = a;
    b_n     = b;
    r_n     = r;
    p_n     = p;
    done_n  = 1'b0;
    busy_n  = busy;
    case (state)
      IDLE: begin
        if (dec_start) begin
          a_n     = c[15:8];
          b_n     = c[7:0];
          r_n     = 3'(ROUNDS);
          busy_n  = 1'b1;
          state_n = RND_B;
        end
      end
      RND_B: begin
        b_n     = rotr8(b - key_b, a[2:0]) ^ a;
        state_n = RND_A;
      end
      RND_A: begin
        a_n     = rotr8(a - key_a, b[2:0]) ^ b;
        r_n     = r - 3'd1;
        state_n = (r == 3'd1) ? POST : RND_B;
      end
      POST: begin
        p_n     = {a - key_0, b - key_1};
        done_n  = 1'b1;
        busy_n  = 1'b0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      a        <= '0;
      b        <= '0;
      r        <= '0;
      p        <= '0;
      dec_done <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      a        <= a_n;
      b        <= b_n;
      r        <= r_n;
      p        <= p_n;
      dec_done <= done_n;
      busy     <= busy_n;
    end
  end

endmodule

// File: tb/tb_rc5_dec_16bit.sv
// tb/tb_rc5_dec_16bit.sv - self-checking bench for rc5_dec_16bit
module tb_rc5_dec_16bit;
  localparam int ROUNDS = 1;
  localparam int KW = 2*ROUNDS + 2;
  localparam int LAT = 2*ROUNDS + 1;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic            dec_start = 1'b0;
  logic [15:0]     c = '0;
  logic [8*KW-1:0] s = '0;
  logic [15:0]     p;
  logic            dec_done;
  logic            busy;

  int n_cmp = 0;
  int n_bad = 0;

  rc5_dec_16bit #(.ROUNDS(ROUNDS)) dut (
    .clock(clock), .reset(reset), .dec_start(dec_start), .c(c),
    .s(s), .p(p), .dec_done(dec_done), .busy(busy)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    logic [7:0] y;
    y = x;
    for (int k = 0; k < n % 8; k++) y = {y[6:0], y[7]};
    return y;
  endfunction

  // Forward cipher: the decryptor must return the original plaintext.
  function automatic logic [15:0] encrypt(input logic [15:0] pt, input logic [8*KW-1:0] key);
    logic [7:0] ea, eb;
    ea = pt[15:8] + key[7:0];
    eb = pt[7:0] + key[15:8];
    for (int i = 1; i <= ROUNDS; i++) begin
      ea = rotl(ea ^ eb, int'(eb) % 8) + key[16*i +: 8];
      eb = rotl(eb ^ ea, int'(ea) % 8) + key[16*i + 8 +: 8];
    end
    return {ea, eb};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [15:0] cv, output logic [15:0] pout);
    int lat;
    lat = 0;
    pout = 'x;
    @(negedge clock);
    c = cv;
    dec_start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    dec_start = 1'b0;
    check({tag, "_busy0"}, 32'(busy), 32'd1);
    for (int e = 1; e <= 20; e++) begin
      @(posedge clock);
      @(negedge clock);
      if (dec_done) begin
        lat = e;
        pout = p;
        check({tag, "_busy_done"}, 32'(busy), 32'd0);
        break;
      end
      check({tag, "_busy"}, 32'(busy), 32'd1);
    end
    check({tag, "_latency"}, 32'(lat), 32'(LAT));
  endtask

  initial begin
    logic [15:0] res, pt, got0, got1;
    logic [8*KW-1:0] key;
    int pulses, t0, t1;

    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      check("idle_p", 32'(p), 32'h0);
      check("idle_done", 32'(dec_done), 32'h0);
      check("idle_busy", 32'(busy), 32'h0);
    end

    s = 32'hFFFF_1020;
    run_op("vec0", 16'h2F9E, res);
    check("vec0_p", 32'(res), 32'h0000);
    run_op("vec1", 16'h6687, res);
    check("vec1_p", 32'(res), 32'h1234);

    // Request while busy must be dropped.
    @(negedge clock);
    c = 16'h6687;
    dec_start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    c = 16'h1111;
    @(posedge clock);
    @(negedge clock);
    dec_start = 1'b0;
    pulses = 0;
    res = '0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (dec_done) begin
        pulses++;
        res = p;
      end
    end
    check("ignore_pulses", 32'(pulses), 32'd1);
    check("ignore_p", 32'(res), 32'h1234);
    check("ignore_hold", 32'(p), 32'h1234);

    // Back-to-back with dec_start held high.
    @(negedge clock);
    c = 16'h2F9E;
    dec_start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    c = 16'h6687;
    pulses = 0;
    t0 = 0;
    t1 = 0;
    got0 = 'x;
    got1 = 'x;
    for (int e = 1; e <= 16; e++) begin
      @(posedge clock);
      @(negedge clock);
      if (dec_done) begin
        pulses++;
        if (pulses == 1) begin
          t0 = e; got0 = p;
        end else begin
          t1 = e; got1 = p;
          dec_start = 1'b0;
        end
      end
    end
    dec_start = 1'b0;
    check("b2b_pulses", 32'(pulses), 32'd2);
    check("b2b_gap", 32'(t1 - t0), 32'(2*ROUNDS + 2));
    check("b2b_p0", 32'(got0), 32'h0000);
    check("b2b_p1", 32'(got1), 32'h1234);

    // Reset in flight.
    @(negedge clock);
    c = 16'h6687;
    dec_start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    dec_start = 1'b0;
    @(posedge clock);
    #2 reset = 1'b0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_p", 32'(p), 32'h0);
    check("rst_done", 32'(dec_done), 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (dec_done) pulses++;
    end
    check("rst_no_done", 32'(pulses), 32'd0);
    check("rst_p_after", 32'(p), 32'h0);

    // Key change after acceptance.
    s = 32'hFFFF_1020;
    @(negedge clock);
    c = 16'h6687;
    dec_start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    dec_start = 1'b0;
    s = 32'h00FF_1020;
    res = 'x;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (dec_done) res = p;
    end
`ifdef RC5_DEC_KEY_LATCH_EN
    check("keylatch_p", 32'(res), 32'h1234);
`else
    check("keylive_p", 32'(res), 32'hFF68);
`endif

    for (int i = 0; i < 20; i++) begin
      key = 32'($urandom);
      pt = 16'($urandom);
      s = key;
      run_op("rand", encrypt(pt, key), res);
      check("rand_p", 32'(res), 32'(pt));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
